bram_responder: RTL and testbench
=================================

# bram_responder

Memory-side responder for the CPU's single-port BRAM bus (addra/dina/wea/douta) driven by the memory controller. It holds the data RAM and a small memory-mapped I/O window at the top of the 16-bit address space: an LED register, a free-running cycle counter, and a transmit FIFO drained through a valid/ready stream port. Every access is serviced with one-cycle registered read latency, so the controller can sample `bram_douta` on its next clock.

## Interface

- `DEPTH`, 4096: data RAM words; legal RAM addresses are 0..DEPTH-1, and DEPTH is at most 0xFF00.
- `FIFO_DEPTH`, 8: TX FIFO entries; must be a power of 2 and at least 2.
- `MMIO_BASE`, 16'hFF00: base address of the I/O window (0xFF00..0xFFFF).

Reset: rst, synchronous, active-high; clock wrbk_clk.

- `wrbk_clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `bram_addra`  in  16  access address.
- `bram_dina`  in  16  write data.
- `bram_wea`  in  1  write enable for `bram_addra`.
- `bram_douta`  out  16  registered read data.
- `led_out`  out  16  LED register contents.
- `tx_data`  out  16  FIFO head entry.
- `tx_valid`  out  1  FIFO non-empty.
- `tx_ready`  in  1  consumer accepts `tx_data`.

## Operation

- **Address decode**
  - RAM: addr < DEPTH.
  - Hole: DEPTH <= addr < MMIO_BASE. Reads return 0; writes are ignored.
  - MMIO: addr >= MMIO_BASE. Offsets 0x04..0xFF read 0; writes to them are ignored.
- **RAM**
  - With wea=1, `mem[addr] <= dina`.
  - RAM contents are not reset.
- **LED register (0xFF00, R/W)**
  - A write loads all 16 bits.
  - `led_out` is the register value.
- **Cycle counter (0xFF01)**
  - Increments by 1 every cycle and wraps 0xFFFF -> 0x0000.
  - A write clears it to 0. When a clear and an increment coincide, the clear wins and the value after the edge is 0.
- **TX data (0xFF02, write-only, reads 0)**
  - A write pushes `dina` into the FIFO.
  - If the FIFO is full and no pop occurs on the same edge, the push is dropped and `overflow` is set.
- **Status (0xFF03)**
  - Read layout: bit0 = full, bit1 = empty, bit2 = overflow (sticky), bits[7:4] = FIFO count. For FIFO_DEPTH=8, a count of 8 shows as 4'h8. All other bits read 0.
  - Writing 1 to bit2 clears overflow. Clear has priority over a set on the same edge.
- **FIFO**
  - Circular buffer with a separate count register; pointers wrap modulo FIFO_DEPTH.
  - Pop occurs when `tx_valid && tx_ready` at the rising edge.
  - Push and pop on the same edge:
    - FIFO full: both happen; count is unchanged and overflow is not set.
    - FIFO empty: only the push happens, since `tx_valid`=0.
- **Reset values**
  - Cleared to 0: `bram_douta`, `led_out`, counter, overflow, FIFO count and pointers.
  - Consequently `tx_valid`=0, and status reads 0x0002 (empty).
- **Reset mid-operation**
  - On the reset edge the FIFO is flushed and `tx_valid` is 0 after that edge, even if `tx_ready` is high.
  - Writes presented during reset are ignored, including RAM writes.

## Timing

- **Read latency**
  - `bram_douta` is registered: at edge N it loads the value addressed by `bram_addra` as stored before edge N's write.
  - Read-during-write to the same address returns the old data. The new data is visible on the following edge.
- **Counter reads**
  - Return the pre-increment value at edge N.
- **Status reads**
  - Reflect FIFO and overflow state before edge N's push, pop or clear.
- **Write effect**
  - All writes take effect at the edge where `wea`=1.
  - `led_out` changes at that edge.
  - A pushed entry makes `tx_valid` rise right after that edge when the FIFO was empty.
- **TX outputs**
  - `tx_valid` and `tx_data` derive combinationally from the FIFO count and read pointer only, with no dependence on `tx_ready`.
  - `tx_data` is stable while `tx_valid`=1 and no pop occurs.
- **Throughput**
  - One access per cycle with no stalls.
  - One FIFO pop per cycle.

## Test plan

- **RAM write/read:** write 0xBEEF @0x0010, then read 0x0010 -> `douta`=0xBEEF one edge after the read address. Write 0x1234 @0x0010 with the address held -> that edge returns 0xBEEF, the next edge returns 0x1234.
- **Decode:** write 0x5555 @0x2000 (DEPTH=4096), then read it -> 0x0000. Write 0x00A5 @0xFF00 -> `led_out`=0x00A5 and a read returns 0x00A5.
- **Counter:** release reset, wait 10 cycles, read 0xFF01 -> 0x000A. Write 0xFF01, then read on the next cycle -> 0x0000. Force 0xFFFF plus 1 cycle -> 0x0000.
- **FIFO fill/overflow:** with `tx_ready`=0, push 9 values 1..9 -> status 0x0085 (full, overflow, count 8). Raise `tx_ready` -> `tx_data` sequence 1..8, then `tx_valid`=0 and status 0x0006. Write 0x0004 to 0xFF03 -> status 0x0002.
- **Simultaneous:** FIFO full, `tx_ready`=1, push 0x00AA -> count stays 8, overflow=0, and 0x00AA emerges last. FIFO empty, push while `tx_ready`=1 -> `tx_valid` rises the next cycle with 0x00AA.
- **Reset mid-stream:** FIFO holds 3 entries with `tx_ready`=0, assert `rst` for 1 cycle -> `tx_valid`=0, `led_out`=0, `douta`=0, status 0x0002. A RAM word written before reset still reads back unchanged.

Source files
------------

// File: rtl/bram_responder.sv
// bram_responder: BRAM-bus memory responder with data RAM, LED/counter/TX-FIFO MMIO and one-cycle registered reads
module bram_responder #(
    parameter int          DEPTH      = 4096,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] MMIO_BASE  = 16'hFF00
) (
    input  logic        wrbk_clk,
    input  logic        rst,
    input  logic [15:0] bram_addra,
    input  logic [15:0] bram_dina,
    input  logic        bram_wea,
    output logic [15:0] bram_douta,
    output logic [15:0] led_out,
    output logic [15:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [16:0]   RAM_TOP  = 17'(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    logic [15:0]   mem_q [DEPTH];
    logic [15:0]   fifo_q [FIFO_DEPTH];
    logic [15:0]   douta_q, douta_d, led_q, led_d, ctr_q, ctr_d;
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          is_ram, is_mmio, mmio_we, full, empty, pop, push_req, push;
    logic [7:0]    off;
    logic [15:0]   status, mmio_rd;

    assign bram_douta = douta_q;
    assign led_out    = led_q;
    assign tx_valid   = cnt_q != '0;
    assign tx_data    = fifo_q[rd_q];

    // address decode, read mux and next-state for every MMIO/FIFO register
    always_comb begin
        is_ram   = {1'b0, bram_addra} < RAM_TOP;
        is_mmio  = bram_addra >= MMIO_BASE;
        off      = 8'(bram_addra - MMIO_BASE);
        mmio_we  = bram_wea && is_mmio;
        full     = cnt_q == FULL_CNT;
        empty    = cnt_q == '0;
        status   = {8'h00, 4'(cnt_q), 1'b0, ovf_q, empty, full};
        mmio_rd  = off == 8'd0 ? led_q : off == 8'd1 ? ctr_q : off == 8'd3 ? status : 16'h0000;
        douta_d  = is_ram ? mem_q[bram_addra[AW-1:0]] : is_mmio ? mmio_rd : 16'h0000;
        led_d    = (mmio_we && off == 8'd0) ? bram_dina : led_q;
        ctr_d    = (mmio_we && off == 8'd1) ? 16'h0000 : ctr_q + 16'd1;
        pop      = tx_valid && tx_ready;
        push_req = mmio_we && off == 8'd2;
        push     = push_req && (!full || pop);
        ovf_d    = (mmio_we && off == 8'd3 && bram_dina[2]) ? 1'b0 : (push_req && full && !pop) ? 1'b1 : ovf_q;
        rd_d     = pop ? rd_q + PW'(1) : rd_q;
        wr_d     = push ? wr_q + PW'(1) : wr_q;
        cnt_d    = cnt_q + CW'(push) - CW'(pop);
    end

    // control/state registers, all cleared by reset
    always_ff @(posedge wrbk_clk) begin
        if (rst) begin
            douta_q <= '0;
            led_q   <= '0;
            ctr_q   <= '0;
            ovf_q   <= 1'b0;
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            douta_q <= douta_d;
            led_q   <= led_d;
            ctr_q   <= ctr_d;
            ovf_q   <= ovf_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
        end
    end

    // data RAM write port; contents survive reset but writes during reset are dropped
    always_ff @(posedge wrbk_clk) begin
        if (!rst && bram_wea && is_ram) mem_q[bram_addra[AW-1:0]] <= bram_dina;
    end

    // TX FIFO storage, written only on an accepted push
    always_ff @(posedge wrbk_clk) begin
        if (!rst && push) fifo_q[wr_q] <= bram_dina;
    end
endmodule

// File: tb/tb_bram_responder.sv
// tb_bram_responder: directed plus randomized checks of bram_responder against a queue-based reference model
module tb_bram_responder;
    logic        wrbk_clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] bram_addra = '0, bram_dina = '0;
    logic        bram_wea = 1'b0, tx_ready = 1'b0;
    logic [15:0] bram_douta, led_out, tx_data;
    logic        tx_valid;

    int passed = 0, fails = 0, total = 0;

    logic [15:0] ram [int];
    logic [15:0] q [$];
    logic [15:0] mled = '0, mctr = '0;
    logic        movf = 1'b0;

    bram_responder dut (
        .wrbk_clk(wrbk_clk), .rst(rst), .bram_addra(bram_addra), .bram_dina(bram_dina),
        .bram_wea(bram_wea), .bram_douta(bram_douta), .led_out(led_out), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    always #5 wrbk_clk = ~wrbk_clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mread(input logic [15:0] a, output bit known);
        known = 1'b1;
        if (a < 16'h1000) begin
            known = ram.exists(int'(a));
            return known ? ram[int'(a)] : 16'h0000;
        end
        if (a < 16'hFF00) return 16'h0000;
        case (a)
            16'hFF00: return mled;
            16'hFF01: return mctr;
            16'hFF03: return {8'h00, 4'(q.size()), 1'b0, movf, q.size() == 0, q.size() == 8};
            default:  return 16'h0000;
        endcase
    endfunction

    task automatic mupdate(input logic [15:0] a, input logic [15:0] d, input logic w, input logic r);
        bit pop, full;
        pop  = q.size() != 0 && r;
        full = q.size() == 8;
        mctr = (w && a == 16'hFF01) ? 16'h0000 : mctr + 16'd1;
        if (w && a < 16'h1000) ram[int'(a)] = d;
        if (w && a == 16'hFF00) mled = d;
        if (w && a == 16'hFF03 && d[2]) movf = 1'b0;
        if (pop) void'(q.pop_front());
        if (w && a == 16'hFF02) begin
            if (!full || pop) q.push_back(d);
            else movf = 1'b1;
        end
    endtask

    task automatic outs();
        chk("led", led_out, mled);
        chk("tx_valid", 16'(tx_valid), 16'(q.size() != 0));
        if (q.size() != 0) chk("tx_data", tx_data, q[0]);
    endtask

    task automatic step(input logic [15:0] a, input logic [15:0] d, input logic w, input logic r);
        logic [15:0] exp;
        bit known;
        bram_addra = a; bram_dina = d; bram_wea = w; tx_ready = r;
        exp = mread(a, known);
        @(posedge wrbk_clk);
        mupdate(a, d, w, r);
        #1;
        if (known) chk("douta", bram_douta, exp);
        outs();
    endtask

    task automatic idle(input logic r);
        step(16'h2000, 16'h0000, 1'b0, r);
    endtask

    task automatic do_reset();
        rst = 1'b1; bram_addra = 16'h0020; bram_dina = 16'hFFFF; bram_wea = 1'b1; tx_ready = 1'b1;
        @(posedge wrbk_clk);
        q.delete(); mled = '0; mctr = '0; movf = 1'b0;
        #1;
        rst = 1'b0; bram_wea = 1'b0;
        chk("rst_douta", bram_douta, 16'h0000);
        chk("rst_led", led_out, 16'h0000);
        chk("rst_valid", 16'(tx_valid), 16'h0000);
    endtask

    initial begin
        logic [15:0] a;
        do_reset();
        repeat (10) idle(1'b0);
        step(16'hFF01, 16'h0000, 1'b0, 1'b0);
        chk("ctr_10", bram_douta, 16'h000A);
        step(16'hFF01, 16'h1234, 1'b1, 1'b0);
        step(16'hFF01, 16'h0000, 1'b0, 1'b0);
        chk("ctr_clear", bram_douta, 16'h0000);
        step(16'hFF03, 16'h0000, 1'b0, 1'b0);
        chk("status_reset", bram_douta, 16'h0002);

        step(16'h0010, 16'hBEEF, 1'b1, 1'b0);
        step(16'h0010, 16'h0000, 1'b0, 1'b0);
        chk("ram_rd", bram_douta, 16'hBEEF);
        step(16'h0010, 16'h1234, 1'b1, 1'b0);
        chk("ram_rdw_old", bram_douta, 16'hBEEF);
        step(16'h0010, 16'h0000, 1'b0, 1'b0);
        chk("ram_rdw_new", bram_douta, 16'h1234);

        step(16'h2000, 16'h5555, 1'b1, 1'b0);
        step(16'h2000, 16'h0000, 1'b0, 1'b0);
        chk("hole_rd", bram_douta, 16'h0000);
        step(16'hFF00, 16'h00A5, 1'b1, 1'b0);
        chk("led_wr", led_out, 16'h00A5);
        step(16'hFF00, 16'h0000, 1'b0, 1'b0);
        chk("led_rd", bram_douta, 16'h00A5);

        for (int i = 1; i <= 9; i++) step(16'hFF02, 16'(i), 1'b1, 1'b0);
        step(16'hFF03, 16'h0000, 1'b0, 1'b0);
        chk("status_ovf", bram_douta, 16'h0085);
        for (int i = 1; i <= 8; i++) begin
            chk("drain_data", tx_data, 16'(i));
            idle(1'b1);
        end
        chk("drained_valid", 16'(tx_valid), 16'h0000);
        step(16'hFF03, 16'h0000, 1'b0, 1'b1);
        chk("status_empty_ovf", bram_douta, 16'h0006);
        step(16'hFF03, 16'h0004, 1'b1, 1'b0);
        step(16'hFF03, 16'h0000, 1'b0, 1'b0);
        chk("status_clr", bram_douta, 16'h0002);

        for (int i = 1; i <= 8; i++) step(16'hFF02, 16'(16'h10 + i), 1'b1, 1'b0);
        step(16'hFF02, 16'h00AA, 1'b1, 1'b1);
        step(16'hFF03, 16'h0000, 1'b0, 1'b0);
        chk("status_full_pushpop", bram_douta, 16'h0081);
        repeat (7) idle(1'b1);
        chk("last_aa", tx_data, 16'h00AA);
        idle(1'b1);
        step(16'hFF02, 16'h00AA, 1'b1, 1'b1);
        chk("empty_push_valid", 16'(tx_valid), 16'h0001);
        chk("empty_push_data", tx_data, 16'h00AA);
        idle(1'b1);

        step(16'h0020, 16'hC0DE, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(16'hFF02, 16'(16'h40 + i), 1'b1, 1'b0);
        do_reset();
        step(16'hFF03, 16'h0000, 1'b0, 1'b0);
        chk("status_after_rst", bram_douta, 16'h0002);
        step(16'h0020, 16'h0000, 1'b0, 1'b0);
        chk("ram_kept", bram_douta, 16'hC0DE);

        step(16'hFF01, 16'h0000, 1'b1, 1'b0);
        repeat (65535) idle(1'b0);
        step(16'hFF01, 16'h0000, 1'b0, 1'b0);
        chk("ctr_ffff", bram_douta, 16'hFFFF);
        step(16'hFF01, 16'h0000, 1'b0, 1'b0);
        chk("ctr_wrap", bram_douta, 16'h0000);

        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 4))
                0: a = 16'($urandom_range(0, 15));
                1: a = 16'(32'h1000 + $urandom_range(0, 32'hEEFF));
                2: a = 16'(32'hFF00 + $urandom_range(0, 5));
                3: a = 16'(32'hFF00 + $urandom_range(0, 255));
                default: a = 16'h0FFF;
            endcase
            if ($urandom_range(0, 199) == 0) do_reset();
            else step(a, 16'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
